// File: rtl/recompute_scheduler.sv
// recompute_scheduler: round-robin arbiter that shares one spare recompute
// unit among the faulty PEs of a ROWS x COLS systolic array. It muxes the
// winning PE's operands into the unit and tags each returned product with
// the PE index it came from.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | fault map may be loaded; no issues
// RUN   | one round-robin issue per cycle from eligible faulty requesters
// DRAIN | one cycle with no issue so the last in-flight result returns
module recompute_scheduler #(
    parameter int WORD_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    localparam int N        = ROWS * COLS,
    localparam int IDX_W    = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   fault_map_load,
    input  logic [N-1:0]           fault_map_in,
    input  logic [N-1:0]           req,
    input  logic [N*WORD_SIZE-1:0] weight_bus,
    input  logic [N*WORD_SIZE-1:0] left_bus,
    input  logic [WORD_SIZE-1:0]   ru_result,
    output logic                   ru_start,
    output logic [WORD_SIZE-1:0]   ru_weight,
    output logic [WORD_SIZE-1:0]   ru_left,
    output logic [N-1:0]           grant,
    output logic                   result_valid,
    output logic [IDX_W-1:0]       result_pe_idx,
    output logic [WORD_SIZE-1:0]   result_data,
    output logic                   busy,
    output logic                   illegal_req,
    output logic [15:0]            issue_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [N-1:0]     fault_map;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] issue_idx;
    logic             s1_valid;
    logic [IDX_W-1:0] s1_idx;

    logic [N-1:0]     eligible;
    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand_idx;

    // Round-robin search starting just after the last winner; the PE granted
    // last cycle is masked because its req may still be high for one cycle.
    always_comb begin
        eligible = req & fault_map & ~grant;
        found    = 1'b0;
        winner   = '0;
        cand_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand_idx = IDX_W'((int'(rr_ptr) + k) % N);
            if (!found && eligible[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    // Sequencer, issue registers and the one-stage result tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            fault_map   <= '0;
            rr_ptr      <= IDX_W'(N - 1);
            grant       <= '0;
            ru_start    <= 1'b0;
            ru_weight   <= '0;
            ru_left     <= '0;
            issue_idx   <= '0;
            s1_valid    <= 1'b0;
            s1_idx      <= '0;
            illegal_req <= 1'b0;
            issue_count <= '0;
        end else begin
            s1_valid  <= ru_start;
            s1_idx    <= issue_idx;
            grant     <= '0;
            ru_start  <= 1'b0;
            ru_weight <= '0;
            ru_left   <= '0;
            case (state)
                ST_IDLE: begin
                    if (fault_map_load)
                        fault_map <= fault_map_in;
                    if (enable)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if ((req & ~fault_map) != '0)
                        illegal_req <= 1'b1;
                    if (!enable) begin
                        state <= ST_DRAIN;
                    end else if (found) begin
                        grant         <= N'(1) << winner;
                        ru_start      <= 1'b1;
                        ru_weight     <= weight_bus[int'(winner)*WORD_SIZE +: WORD_SIZE];
                        ru_left       <= left_bus[int'(winner)*WORD_SIZE +: WORD_SIZE];
                        issue_idx     <= winner;
                        rr_ptr        <= winner;
                        if (issue_count != 16'hFFFF)
                            issue_count <= issue_count + 16'd1;
                    end
                end
                ST_DRAIN: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign result_valid  = s1_valid;
    assign result_pe_idx = s1_idx;
    assign result_data   = ru_result;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_recompute_scheduler.sv
// Scoreboard bench for recompute_scheduler: the stimulus process pushes
// expected grants and tagged results; a negedge monitor pops and compares
// whenever the DUT shows a grant or a valid result.
module tb_recompute_scheduler;
    localparam int W = 16;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst, enable, fault_map_load;
    logic [N-1:0]   fault_map_in, req;
    logic [N*W-1:0] weight_bus, left_bus;
    logic [W-1:0]   ru_result;
    logic           ru_start;
    logic [W-1:0]   ru_weight, ru_left;
    logic [N-1:0]   grant;
    logic           result_valid;
    logic [3:0]     result_pe_idx;
    logic [W-1:0]   result_data;
    logic           busy, illegal_req;
    logic [15:0]    issue_count;

    recompute_scheduler #(.WORD_SIZE(W), .ROWS(4), .COLS(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fault_map_load(fault_map_load),
        .fault_map_in(fault_map_in), .req(req), .weight_bus(weight_bus),
        .left_bus(left_bus), .ru_result(ru_result), .ru_start(ru_start),
        .ru_weight(ru_weight), .ru_left(ru_left), .grant(grant),
        .result_valid(result_valid), .result_pe_idx(result_pe_idx),
        .result_data(result_data), .busy(busy), .illegal_req(illegal_req),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    // Recompute unit stand-in: registered truncated product.
    always @(posedge clk) ru_result <= ru_weight * ru_left;

    typedef struct { int idx; int data; } res_t;
    int   gq[$];
    res_t rq[$];
    int   total = 0;
    int   bad   = 0;
    logic auto_drop = 1'b1;
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~grant;
    endtask

    always @(negedge clk) begin : monitor
        int   e;
        res_t r;
        if (grant != '0) begin
            if (gq.size() == 0) begin
                chk("unexpected_grant", grant, 0);
            end else begin
                e = gq.pop_front();
                chk("grant", grant, longint'(1) << e);
            end
            if (prev_grant != '0)
                chk("same_pe_twice", longint'(grant == prev_grant), 0);
        end
        prev_grant = grant;
        if (result_valid) begin
            if (rq.size() == 0) begin
                chk("unexpected_result", result_pe_idx, -1);
            end else begin
                r = rq.pop_front();
                chk("result_idx", result_pe_idx, r.idx);
                chk("result_data", result_data, r.data);
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; fault_map_load = 1'b0;
        fault_map_in = '0; req = '0;
        for (int i = 0; i < N; i++) begin
            weight_bus[i*W +: W] = W'(i + 1);
            left_bus[i*W +: W]   = W'(i + 2);
        end
        weight_bus[4*W +: W]  = 16'd3;      left_bus[4*W +: W]  = 16'd7;
        weight_bus[10*W +: W] = 16'h0300;   left_bus[10*W +: W] = 16'h0101;
        tick(); tick(); rst = 1'b0;

        chk("rst_grant", grant, 0);
        chk("rst_ru_start", ru_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_illegal", illegal_req, 0);
        chk("rst_issue_count", issue_count, 0);

        // single request to PE 4
        fault_map_load = 1'b1; fault_map_in = 16'h0010; enable = 1'b1;
        tick(); fault_map_load = 1'b0;
        chk("run_busy", busy, 1);
        req = 16'h0010; gq.push_back(4); rq.push_back('{idx: 4, data: 21});
        tick();
        chk("single_ru_start", ru_start, 1);
        chk("single_ru_weight", ru_weight, 3);
        chk("single_ru_left", ru_left, 7);
        tick(); tick();
        chk("single_issue_count", issue_count, 1);

        // round robin 0,5,10,15 (PE10 product truncates 0x30300 -> 0x0300)
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_issue_count", issue_count, 0);
        fault_map_load = 1'b1; fault_map_in = 16'h8421;
        tick(); fault_map_load = 1'b0;
        req = 16'h8421;
        gq.push_back(0); gq.push_back(5); gq.push_back(10); gq.push_back(15);
        rq.push_back('{idx: 0, data: 2});    rq.push_back('{idx: 5, data: 42});
        rq.push_back('{idx: 10, data: 768}); rq.push_back('{idx: 15, data: 272});
        repeat (6) tick();
        chk("rr_issue_count", issue_count, 4);

        // wrap and fairness: req 0 and 15 held
        auto_drop = 1'b0; req = 16'h8001;
        for (int i = 0; i < 6; i++) begin
            gq.push_back((i % 2 == 0) ? 0 : 15);
            rq.push_back((i % 2 == 0) ? '{idx: 0, data: 2} : '{idx: 15, data: 272});
        end
        repeat (6) tick();
        req = '0;
        repeat (3) tick();
        auto_drop = 1'b1;
        chk("fair_issue_count", issue_count, 10);

        // illegal requests and ignored map load
        enable = 1'b0; tick(); tick();
        chk("idle_busy", busy, 0);
        fault_map_load = 1'b1; fault_map_in = 16'h0001; enable = 1'b1;
        tick(); fault_map_load = 1'b0;
        chk("illegal_clear", illegal_req, 0);
        req = 16'h0008; tick(); tick();
        chk("illegal_set", illegal_req, 1);
        chk("illegal_no_grant", grant, 0);
        req = '0; tick();
        chk("illegal_sticky", illegal_req, 1);
        fault_map_load = 1'b1; fault_map_in = 16'hFFFF; tick(); fault_map_load = 1'b0;
        req = 16'h0002; tick();
        chk("map_kept_a", grant, 0);
        tick();
        chk("map_kept_b", grant, 0);
        req = 16'h0001; gq.push_back(0); rq.push_back('{idx: 0, data: 2});
        tick();
        chk("legal_grant", grant, 16'h0001);
        tick(); tick();

        // drain: issue to PE 2, enable drops, PE 0 request must wait
        enable = 1'b0; tick(); tick();
        fault_map_load = 1'b1; fault_map_in = 16'h0005; enable = 1'b1;
        tick(); fault_map_load = 1'b0;
        req = 16'h0005; gq.push_back(2); rq.push_back('{idx: 2, data: 12});
        tick();
        chk("drain_e0_start", ru_start, 1);
        enable = 1'b0;
        tick();
        chk("drain_e1_no_issue", ru_start, 0);
        chk("drain_e1_grant", grant, 0);
        chk("drain_e1_busy", busy, 1);
        chk("drain_e1_result", result_valid, 1);
        enable = 1'b1; req = '0;
        tick();
        chk("drain_e2_busy", busy, 0);
        chk("drain_e2_result", result_valid, 0);
        tick();
        chk("drain_e3_busy", busy, 1);

        // reset mid-RUN with an issue in flight
        req = 16'h0004; gq.push_back(2);
        tick();
        chk("inflight_start", ru_start, 1);
        rst = 1'b1; tick();
        chk("inflight_discard", result_valid, 0);
        chk("inflight_grant", grant, 0);
        tick(); rst = 1'b0; enable = 1'b0;
        chk("rst3_grant", grant, 0);
        chk("rst3_ru_start", ru_start, 0);
        chk("rst3_ru_weight", ru_weight, 0);
        chk("rst3_ru_left", ru_left, 0);
        chk("rst3_busy", busy, 0);
        chk("rst3_result_valid", result_valid, 0);
        chk("rst3_pe_idx", result_pe_idx, 0);
        chk("rst3_illegal", illegal_req, 0);
        chk("rst3_issue_count", issue_count, 0);
        tick(); tick();

        chk("grant_queue_empty", gq.size(), 0);
        chk("result_queue_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
